// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Combinational reads with write-through bypass; synchronous writes.
//
// Ports:
//   clk_i       clock; all state updates on the rising edge
//   reset_i     synchronous active-high reset; overrides every other input
//   rd_addr_i   NRD read addresses, port i at [i*AW +: AW]
//   rd_data_o   NRD read data words, port i at [i*XLEN +: XLEN]
//   rd_busy_o   per read port: source register still awaiting writeback
//   wr_en_i     per write port enable (higher index = younger)
//   wr_addr_i   per write port address
//   wr_data_i   per write port data
//   iss_en_i    reserve destination iss_rd_i (set its busy bit)
//   iss_rd_i    destination register being reserved
//   flush_i     clear all busy bits; data array is untouched
//   busy_cnt_o  registered count of busy registers
module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = AW + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                flush_i,
    output logic [CW-1:0]       busy_cnt_o
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic [AW-1:0]    wa     [NWR];
    logic             wvld   [NWR];
    logic [AW-1:0]    ra     [NRD];
    logic [XLEN-1:0]  rdat   [NRD];
    logic             rhit   [NRD];

    // Decode write ports once; writes to r0 are dropped here.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wa[j]   = wr_addr_i[j*AW +: AW];
            wvld[j] = wr_en_i[j] && (wa[j] != '0);
        end
    end

    // Next state. Ascending port order lets the youngest write win,
    // and the issue set is applied last so it beats both the
    // writeback clear and a same-cycle flush.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wvld[j]) begin
                regs_d[wa[j]] = wr_data_i[j*XLEN +: XLEN];
                busy_d[wa[j]] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        if (iss_en_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int k = 0; k < NREGS; k++) begin
            cnt_d = cnt_d + CW'(busy_d[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Reads: array value, overridden by the youngest matching write.
    // A matching write also hides the busy bit it is about to clear;
    // an issue set is deliberately not forwarded.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            ra[i]   = rd_addr_i[i*AW +: AW];
            rdat[i] = regs_q[ra[i]];
            rhit[i] = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wvld[j] && (wa[j] == ra[i])) begin
                    rdat[i] = wr_data_i[j*XLEN +: XLEN];
                    rhit[i] = 1'b1;
                end
            end
            if (ra[i] != '0) begin
                rd_data_o[i*XLEN +: XLEN] = rdat[i];
                rd_busy_o[i]              = busy_q[ra[i]] & ~rhit[i];
            end
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule
